// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and defaults for the HUB75 receive-capture block.
//   WIDTH_DEF     default pixels per shifted line
//   ADDR_BITS_DEF default row-address width {E,D,C,B,A}
//   COL_BITS      column-index width for the default line width
//   pixel_t       one shifted pixel: upper-half rgb1 and lower-half rgb2
//   state_e       line drain FSM encoding
package hub75_pkg;

  localparam int WIDTH_DEF     = 64;
  localparam int ADDR_BITS_DEF = 5;
  localparam int COL_BITS      = $clog2(WIDTH_DEF);

  typedef struct packed {
    logic [2:0] rgb1;
    logic [2:0] rgb2;
  } pixel_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/hub75_rx_capture_if.sv
// hub75_rx_capture_if: pixel-beat stream leaving the capture block.
//   valid/ready  beat handshake (beat fires on valid & ready)
//   row          row address of the line being drained
//   col          column index of the beat (0 = oldest shifted pixel)
//   rgb1/rgb2    upper-half / lower-half pixel
//   last         high on the beat with col == WIDTH-1
// Modports: master = capture block (drives the beat), slave = consumer.
interface hub75_rx_capture_if
  import hub75_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int COL_W     = COL_BITS
);
  logic                 valid;
  logic                 ready;
  logic [ADDR_BITS-1:0] row;
  logic [COL_W-1:0]     col;
  logic [2:0]           rgb1;
  logic [2:0]           rgb2;
  logic                 last;

  modport master (output valid, row, col, rgb1, rgb2, last, input ready);
  modport slave  (input valid, row, col, rgb1, rgb2, last, output ready);
endinterface

// File: rtl/hub75_input_sync.sv
// hub75_input_sync: brings every HUB75 input into the clk domain through
// SYNC_STAGES flops, and derives single-cycle edge pulses from the synced
// pixel clock and latch. Address/RGB/OE leave from the same synced stage as
// the edge detector, so data is aligned with the edge it belongs to.
//   clk, rst_n            system clock, async active-low reset
//   h75_*                 raw HUB75 inputs (async to clk)
//   clk_rise / lat_fall   1-cycle pulses on synced h75_clk rise / h75_lat fall
//   oe_sync, addr_sync    synced output-enable and row address
//   pix_sync              synced {rgb1,rgb2}
module hub75_input_sync
  import hub75_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 h75_clk,
  input  logic                 h75_lat,
  input  logic                 h75_oe,
  input  logic [ADDR_BITS-1:0] h75_addr,
  input  logic [2:0]           h75_rgb1,
  input  logic [2:0]           h75_rgb2,
  output logic                 clk_rise,
  output logic                 lat_fall,
  output logic                 oe_sync,
  output logic [ADDR_BITS-1:0] addr_sync,
  output pixel_t               pix_sync
);
  localparam int BUS_W = ADDR_BITS + 9;

  logic [BUS_W-1:0] bus_in_s;
  logic [BUS_W-1:0] bus_sync_s;
  logic [BUS_W-1:0] stage_r [SYNC_STAGES];
  logic             clk_prev_r;
  logic             lat_prev_r;

  assign bus_in_s = {h75_clk, h75_lat, h75_oe, h75_addr, h75_rgb1, h75_rgb2};

  // Synchronizer chain shared by all HUB75 inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= bus_in_s;
      for (int i = 1; i < SYNC_STAGES; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign bus_sync_s = stage_r[SYNC_STAGES-1];

  // Previous synced levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_r <= 1'b0;
      lat_prev_r <= 1'b0;
    end else begin
      clk_prev_r <= bus_sync_s[BUS_W-1];
      lat_prev_r <= bus_sync_s[BUS_W-2];
    end
  end

  assign clk_rise  = bus_sync_s[BUS_W-1] & ~clk_prev_r;
  assign lat_fall  = ~bus_sync_s[BUS_W-2] & lat_prev_r;
  assign oe_sync   = bus_sync_s[BUS_W-3];
  assign addr_sync = bus_sync_s[6 +: ADDR_BITS];
  assign pix_sync  = pixel_t'(bus_sync_s[5:0]);
endmodule

// File: rtl/hub75_rx_capture.sv
// hub75_rx_capture: samples a HUB75 bus with clk, rebuilds each latched line
// and streams it out one pixel per beat (oldest shifted pixel first).
//   clk, rst_n        system clock, async active-low reset
//   h75_clk/lat/oe    HUB75 pixel clock, latch, output enable (active-low)
//   h75_addr          row address {E,D,C,B,A}
//   h75_rgb1/rgb2     upper/lower-half pixel data
//   out_if            beat stream (master modport), see hub75_rx_capture_if
//   overrun           1-cycle pulse: latch arrived while a line was draining
//   col_err           1-cycle pulse: shift count since last latch != WIDTH
//   oe_on_cycles      (only with HUB75_RX_OE_STATS_EN) clk cycles with OE
//                     active between latches, snapshotted at accepted latch
// Optional feature macro: HUB75_RX_OE_STATS_EN.
module hub75_rx_capture
  import hub75_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     h75_clk,
  input  logic                     h75_lat,
  input  logic                     h75_oe,
  input  logic [ADDR_BITS-1:0]     h75_addr,
  input  logic [2:0]               h75_rgb1,
  input  logic [2:0]               h75_rgb2,
  hub75_rx_capture_if.master       out_if,
  output logic                     overrun,
  output logic                     col_err
`ifdef HUB75_RX_OE_STATS_EN
  ,
  output logic [15:0]              oe_on_cycles
`endif
);
  localparam int COL_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

  logic                 clk_rise_s, lat_fall_s, oe_sync_s;
  logic [ADDR_BITS-1:0] addr_sync_s;
  pixel_t               pix_sync_s;

  state_e               state_r, state_nxt_s;
  logic [COL_W-1:0]     col_r, col_nxt_s;
  logic                 accept_s;
  pixel_t               pix_nxt_s;
  logic [CNT_W-1:0]     shift_cnt_r;
  pixel_t               shift_r [WIDTH];
  pixel_t               hold_r  [WIDTH];
  logic [ADDR_BITS-1:0] row_r;
  logic                 valid_r, last_r, overrun_r, col_err_r;
  pixel_t               pix_r;

  hub75_input_sync #(.SYNC_STAGES(SYNC_STAGES), .ADDR_BITS(ADDR_BITS)) u_sync (
    .clk(clk), .rst_n(rst_n),
    .h75_clk(h75_clk), .h75_lat(h75_lat), .h75_oe(h75_oe),
    .h75_addr(h75_addr), .h75_rgb1(h75_rgb1), .h75_rgb2(h75_rgb2),
    .clk_rise(clk_rise_s), .lat_fall(lat_fall_s), .oe_sync(oe_sync_s),
    .addr_sync(addr_sync_s), .pix_sync(pix_sync_s)
  );

  // Next-state / column logic of the line drain FSM.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lat_fall_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_DRAIN;
          col_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_if.ready) begin
          if (col_r == COL_LAST) begin
            state_nxt_s = ST_IDLE;
            col_nxt_s   = '0;
          end else begin
            col_nxt_s = col_r + COL_W'(1);
          end
        end else begin
          col_nxt_s = col_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        col_nxt_s   = '0;
      end
    endcase
    // Hold is loaded on the same edge as an accepted latch, so column 0
    // must come straight from the shift register on that cycle.
    if (accept_s) begin
      pix_nxt_s = shift_r[0];
    end else begin
      pix_nxt_s = hold_r[col_nxt_s];
    end
  end

  // FSM state, column and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      col_r   <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      pix_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      col_r   <= col_nxt_s;
      valid_r <= (state_nxt_s == ST_DRAIN);
      last_r  <= (state_nxt_s == ST_DRAIN) && (col_nxt_s == COL_LAST);
      pix_r   <= pix_nxt_s;
    end
  end

  // Pixel shift register (index 0 = oldest) and saturating shift counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) shift_r[i] <= '0;
      shift_cnt_r <= '0;
    end else begin
      if (clk_rise_s) begin
        for (int i = 0; i < WIDTH - 1; i++) shift_r[i] <= shift_r[i+1];
        shift_r[WIDTH-1] <= pix_sync_s;
      end
      if (lat_fall_s) begin
        shift_cnt_r <= '0;
      end else if (clk_rise_s && (shift_cnt_r != CNT_W'(WIDTH + 1))) begin
        shift_cnt_r <= shift_cnt_r + CNT_W'(1);
      end
    end
  end

  // Line hold buffer, row address and latch status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) hold_r[i] <= '0;
      row_r     <= '0;
      overrun_r <= 1'b0;
      col_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        for (int i = 0; i < WIDTH; i++) hold_r[i] <= shift_r[i];
        row_r <= addr_sync_s;
      end
      overrun_r <= lat_fall_s && (state_r == ST_DRAIN);
      col_err_r <= lat_fall_s && (shift_cnt_r != CNT_W'(WIDTH));
    end
  end

  assign out_if.valid = valid_r;
  assign out_if.row   = row_r;
  assign out_if.col   = col_r;
  assign out_if.rgb1  = pix_r.rgb1;
  assign out_if.rgb2  = pix_r.rgb2;
  assign out_if.last  = last_r;
  assign overrun      = overrun_r;
  assign col_err      = col_err_r;

`ifdef HUB75_RX_OE_STATS_EN
  logic [15:0] oe_cnt_r, oe_snap_r;

  // OE-active cycle counter, cleared at every latch edge, snapshotted on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_cnt_r  <= 16'd0;
      oe_snap_r <= 16'd0;
    end else begin
      if (lat_fall_s) begin
        oe_cnt_r <= 16'd0;
      end else if (!oe_sync_s && (oe_cnt_r != 16'hFFFF)) begin
        oe_cnt_r <= oe_cnt_r + 16'd1;
      end
      if (accept_s) begin
        oe_snap_r <= oe_cnt_r;
      end
    end
  end

  assign oe_on_cycles = oe_snap_r;
`else
  logic unused_oe_s;
  assign unused_oe_s = oe_sync_s;
`endif
endmodule

// File: tb/tb_hub75_rx_capture.sv
// tb_hub75_rx_capture: directed bench for hub75_rx_capture. A HUB75 driver
// task shifts pixels with slow pixel-clock levels; a queue holds the last 64
// shifted pixels as the expected line contents at each accepted latch.
module tb_hub75_rx_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       h75_clk = 1'b0, h75_lat = 1'b0, h75_oe = 1'b1;
  logic [4:0] h75_addr = 5'd0;
  logic [2:0] h75_rgb1 = 3'd0, h75_rgb2 = 3'd0;
  logic       out_ready = 1'b0;
  logic       overrun, col_err;
`ifdef HUB75_RX_OE_STATS_EN
  logic [15:0] oe_on_cycles;
`endif

  hub75_rx_capture_if #(.ADDR_BITS(5), .COL_W(6)) out_if ();
  assign out_if.ready = out_ready;

  hub75_rx_capture dut (
    .clk(clk), .rst_n(rst_n),
    .h75_clk(h75_clk), .h75_lat(h75_lat), .h75_oe(h75_oe),
    .h75_addr(h75_addr), .h75_rgb1(h75_rgb1), .h75_rgb2(h75_rgb2),
    .out_if(out_if), .overrun(overrun), .col_err(col_err)
`ifdef HUB75_RX_OE_STATS_EN
    , .oe_on_cycles(oe_on_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int cerr_cnt = 0;
  int valid_cycles = 0;
  logic [5:0] model_q [$];
  logic [5:0] exp_line [64];

  // Pulse monitor for the latch status outputs.
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (col_err) cerr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pat(input int id, input int c);
    logic [2:0] r1, r2;
    if (id == 0) begin
      r1 = 3'(c % 8);
      r2 = 3'((~c) & 7);
    end else begin
      r1 = 3'((c * 3 + id) % 8);
      r2 = 3'((c * 5 + id * 2 + 1) % 8);
    end
    return {r1, r2};
  endfunction

  task automatic model_reset();
    model_q.delete();
    repeat (64) model_q.push_back(6'd0);
  endtask

  task automatic shift_px(input logic [5:0] p);
    h75_rgb1 = p[5:3];
    h75_rgb2 = p[2:0];
    h75_clk  = 1'b0;
    wait_clk(3);
    h75_clk = 1'b1;
    wait_clk(3);
    h75_clk = 1'b0;
    model_q.push_back(p);
    if (model_q.size() > 64) void'(model_q.pop_front());
  endtask

  task automatic shift_line(input int id, input int n);
    for (int i = 0; i < n; i++) shift_px(pat(id, i));
  endtask

  task automatic latch_line(input logic [4:0] addr, input bit accepted);
    h75_clk  = 1'b0;
    h75_addr = addr;
    wait_clk(3);
    h75_lat = 1'b1;
    wait_clk(3);
    h75_lat = 1'b0;
    if (accepted) begin
      for (int i = 0; i < 64; i++) exp_line[i] = model_q[i];
    end
    wait_clk(4);
  endtask

  // Consumes beats from_col..to_col; mode 0 = always ready, 1 = ready 1-of-3.
  // Every valid sample (stalled or firing) is compared with the expected beat.
  task automatic drain(input int from_col, input int to_col, input int mode, input logic [4:0] row);
    int c = from_col;
    int cyc = 0;
    logic [17:0] got, exp;
    valid_cycles = 0;
    while (c <= to_col && cyc < 1000) begin
      out_ready = (mode == 0) || (cyc % 3 == 0);
      @(negedge clk);
      if (out_if.valid) begin
        valid_cycles++;
        got = {out_if.row, out_if.col, out_if.last, out_if.rgb1, out_if.rgb2};
        exp = {row, 6'(c), (c == 63), exp_line[c]};
        check("beat", 32'(got), 32'(exp));
        if (out_ready) c++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (c <= to_col) check("drain_timeout", 32'(c), 32'(to_col + 1));
  endtask

  initial begin
    int ob, cb;
    model_reset();
    wait_clk(3);
    @(negedge clk);
    check("rst_valid", 32'(out_if.valid), 32'd0);
    check("rst_flags", 32'({overrun, col_err, out_if.last}), 32'd0);
    check("rst_data", 32'({out_if.row, out_if.col, out_if.rgb1, out_if.rgb2}), 32'd0);
    rst_n = 1'b1;
    wait_clk(2);

    // Loopback: full line, row 17, free-flowing consumer.
    ob = ovr_cnt; cb = cerr_cnt;
    shift_line(0, 64);
    latch_line(5'd17, 1'b1);
    drain(0, 63, 0, 5'd17);
    check("throughput", 32'(valid_cycles), 32'd64);
    @(negedge clk);
    check("idle_after", 32'(out_if.valid), 32'd0);
    check("col_err_none", 32'(cerr_cnt - cb), 32'd0);
    check("overrun_none", 32'(ovr_cnt - ob), 32'd0);
    wait_clk(1);

    // Backpressure: same line, consumer ready one cycle in three.
    shift_line(0, 64);
    latch_line(5'd17, 1'b1);
    drain(0, 63, 1, 5'd17);
    check("bp_stalled", 32'(valid_cycles > 64), 32'd1);

    // Overrun: second line latched while the first is stalled at beat 10.
    ob = ovr_cnt; cb = cerr_cnt;
    shift_line(1, 64);
    latch_line(5'd3, 1'b1);
    drain(0, 9, 0, 5'd3);
    shift_line(2, 64);
    latch_line(5'd9, 1'b0);
    check("overrun_pulse", 32'(ovr_cnt - ob), 32'd1);
    drain(10, 63, 0, 5'd3);
    check("ovr_col_err", 32'(cerr_cnt - cb), 32'd0);
    wait_clk(10);
    @(negedge clk);
    check("dropped_line", 32'(out_if.valid), 32'd0);
    wait_clk(1);

    // Short line: 60 shifts leave the oldest 4 slots from the previous line.
    cb = cerr_cnt;
    shift_line(3, 60);
    latch_line(5'd5, 1'b1);
    check("short_head", 32'(exp_line[0]), 32'(pat(2, 60)));
    drain(0, 63, 0, 5'd5);
    check("short_col_err", 32'(cerr_cnt - cb), 32'd1);

    // Long line: 70 shifts keep the last 64.
    cb = cerr_cnt;
    shift_line(4, 70);
    latch_line(5'd6, 1'b1);
    check("long_head", 32'(exp_line[0]), 32'(pat(4, 6)));
    drain(0, 63, 0, 5'd6);
    check("long_col_err", 32'(cerr_cnt - cb), 32'd1);

`ifdef HUB75_RX_OE_STATS_EN
    // OE statistics: 300 cycles of active OE between two latches.
    h75_oe = 1'b0;
    wait_clk(300);
    h75_oe = 1'b1;
    shift_line(5, 64);
    latch_line(5'd7, 1'b1);
    check("oe_cycles", 32'((oe_on_cycles >= 16'd299) && (oe_on_cycles <= 16'd301)), 32'd1);
    drain(0, 63, 0, 5'd7);
`endif

    // Reset in the middle of a drain, then a clean line afterwards.
    shift_line(6, 64);
    latch_line(5'd21, 1'b1);
    drain(0, 4, 0, 5'd21);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_if.valid), 32'd0);
    check("rst_mid_flags", 32'({overrun, col_err, out_if.col}), 32'd0);
    model_reset();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    cb = cerr_cnt;
    shift_line(7, 64);
    latch_line(5'd30, 1'b1);
    drain(0, 63, 0, 5'd30);
    check("post_rst_col_err", 32'(cerr_cnt - cb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
